// File: rtl/demux_8_pkg.sv
// Shared constants for the 8-way demux register bank: FSM encoding,
// active-low one-hot select codes and error-counter geometry.
package demux_8_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_NACK = 2'd2;

    localparam int SEL_W = 8;

    localparam logic [SEL_W-1:0] SEL_CH0 = 8'hFE;
    localparam logic [SEL_W-1:0] SEL_CH1 = 8'hFD;
    localparam logic [SEL_W-1:0] SEL_CH2 = 8'hFB;
    localparam logic [SEL_W-1:0] SEL_CH3 = 8'hF7;
    localparam logic [SEL_W-1:0] SEL_CH4 = 8'hEF;
    localparam logic [SEL_W-1:0] SEL_CH5 = 8'hDF;
    localparam logic [SEL_W-1:0] SEL_CH6 = 8'hBF;
    localparam logic [SEL_W-1:0] SEL_CH7 = 8'h7F;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_ONE = 8'd1;

endpackage

// File: rtl/demux_8_decoder.sv
// Maps an active-low one-hot select code to a channel index; anything that is
// not exactly one of the eight listed codes is reported as invalid.
module demux_8_decoder
    import demux_8_pkg::*;
(
    input  logic [SEL_W-1:0] sel_i,
    output logic [2:0]       idx_o,
    output logic             valid_o
);

    // Exact-match decode so multi-zero, all-ones and all-zero codes fall to default
    always_comb begin
        idx_o   = 3'd0;
        valid_o = 1'b0;
        case (sel_i)
            SEL_CH0: begin idx_o = 3'd0; valid_o = 1'b1; end
            SEL_CH1: begin idx_o = 3'd1; valid_o = 1'b1; end
            SEL_CH2: begin idx_o = 3'd2; valid_o = 1'b1; end
            SEL_CH3: begin idx_o = 3'd3; valid_o = 1'b1; end
            SEL_CH4: begin idx_o = 3'd4; valid_o = 1'b1; end
            SEL_CH5: begin idx_o = 3'd5; valid_o = 1'b1; end
            SEL_CH6: begin idx_o = 3'd6; valid_o = 1'b1; end
            SEL_CH7: begin idx_o = 3'd7; valid_o = 1'b1; end
            default: begin idx_o = 3'd0; valid_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/demux_8_regbank.sv
// Eight holding registers written under a four-phase write/ack handshake.
// Invalid select codes raise error_Out instead and bump a saturating counter.
module demux_8_regbank
    import demux_8_pkg::*;
#(
    parameter int DATAWIDTH_DEMUX_SELECTION = 8,
    parameter int DATAWIDTH_BUS             = 32
) (
    input  logic                                 DEMUX_8_CLOCK_50,
    input  logic                                 DEMUX_8_RESET_InHigh,
    input  logic                                 DEMUX_8_write_In,
    input  logic [DATAWIDTH_BUS-1:0]             DEMUX_8_data_InBUS,
    input  logic [DATAWIDTH_DEMUX_SELECTION-1:0] DEMUX_8_selection_InBUS,
    output logic [DATAWIDTH_BUS-1:0]             DEMUX_8_data0_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]             DEMUX_8_data1_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]             DEMUX_8_data2_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]             DEMUX_8_data3_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]             DEMUX_8_data4_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]             DEMUX_8_data5_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]             DEMUX_8_data6_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]             DEMUX_8_data7_OutBUS,
    output logic                                 DEMUX_8_ack_Out,
    output logic                                 DEMUX_8_error_Out,
    output logic [ERR_CNT_W-1:0]                 DEMUX_8_errorCount_OutBUS
);

    logic [1:0]               state_q, state_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [ERR_CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATAWIDTH_BUS-1:0] data_q [0:7];
    logic [DATAWIDTH_BUS-1:0] data_d [0:7];

    logic [2:0] chan_idx_s;
    logic       chan_valid_s;
    logic       accept_s;
    logic [7:0] wr_en_s;

    demux_8_decoder u_decoder (
        .sel_i   (DEMUX_8_selection_InBUS),
        .idx_o   (chan_idx_s),
        .valid_o (chan_valid_s)
    );

    // A request is taken only from IDLE, so a held write_In never retriggers
    assign accept_s = (state_q == ST_IDLE) && DEMUX_8_write_In;
    assign wr_en_s  = (accept_s && chan_valid_s) ? (8'd1 << chan_idx_s) : 8'd0;

    // State, flag, counter and data-bank registers
    always_ff @(posedge DEMUX_8_CLOCK_50) begin
        if (DEMUX_8_RESET_InHigh) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= {ERR_CNT_W{1'b0}};
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= {DATAWIDTH_BUS{1'b0}};
            end
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (DEMUX_8_write_In) begin
                    state_d = chan_valid_s ? ST_ACK : ST_NACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK:  state_d = DEMUX_8_write_In ? ST_ACK  : ST_IDLE;
            ST_NACK: state_d = DEMUX_8_write_In ? ST_NACK : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore flags decoded from the next state so they land in flops alongside it
    always_comb begin
        ack_d = (state_d == ST_ACK);
        err_d = (state_d == ST_NACK);
    end

    // Bank write-enables and saturating reject counter
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if (wr_en_s[i]) begin
                data_d[i] = DEMUX_8_data_InBUS;
            end else begin
                data_d[i] = data_q[i];
            end
        end
        if (accept_s && !chan_valid_s && (cnt_q != ERR_CNT_MAX)) begin
            cnt_d = cnt_q + ERR_CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign DEMUX_8_data0_OutBUS      = data_q[0];
    assign DEMUX_8_data1_OutBUS      = data_q[1];
    assign DEMUX_8_data2_OutBUS      = data_q[2];
    assign DEMUX_8_data3_OutBUS      = data_q[3];
    assign DEMUX_8_data4_OutBUS      = data_q[4];
    assign DEMUX_8_data5_OutBUS      = data_q[5];
    assign DEMUX_8_data6_OutBUS      = data_q[6];
    assign DEMUX_8_data7_OutBUS      = data_q[7];
    assign DEMUX_8_ack_Out           = ack_q;
    assign DEMUX_8_error_Out         = err_q;
    assign DEMUX_8_errorCount_OutBUS = cnt_q;

endmodule

// File: doc/demux_8_regbank.md
# demux_8_regbank

Write-side counterpart of the 8-way output multiplexer: accepts one data word plus an active-low one-hot channel select under a four-phase request/acknowledge handshake and stores the word into one of eight holding registers. The eight registers are presented in parallel on eight output buses, which feed the multiplexer's eight data inputs. Invalid select codes are rejected, flagged and counted; no register is written for them.

## Interface

Parameters
- DATAWIDTH_DEMUX_SELECTION, 8, width of the active-low one-hot select bus
- DATAWIDTH_BUS, 32, width of the data word and of each holding register

Ports
- DEMUX_8_CLOCK_50  input  1  single clock for the block; all state changes on its rising edge
- DEMUX_8_RESET_InHigh  input  1  reset, synchronous and active-high
- DEMUX_8_write_In  input  1  write request, level; held high until ack or error is seen
- DEMUX_8_data_InBUS  input  DATAWIDTH_BUS  word to store
- DEMUX_8_selection_InBUS  input  DATAWIDTH_DEMUX_SELECTION  active-low one-hot channel code
- DEMUX_8_data0_OutBUS … DEMUX_8_data7_OutBUS  output  DATAWIDTH_BUS each  holding registers 0-7
- DEMUX_8_ack_Out  output  1  write accepted, held through handshake
- DEMUX_8_error_Out  output  1  select rejected, held through handshake
- DEMUX_8_errorCount_OutBUS  output  8  saturating count of rejected requests

## Operation

- Valid select codes are the eight active-low one-hot values: 8'hFE → ch0, 8'hFD → ch1, 8'hFB → ch2, 8'hF7 → ch3, 8'hEF → ch4, 8'hDF → ch5, 8'hBF → ch6, 8'h7F → ch7. Every other value is invalid, including 8'hFF, 8'h00 and any code with more than one zero bit.
- FSM states: IDLE, ACK, NACK.
  - IDLE, write_In=0: stay.
  - IDLE, write_In=1, select valid: write data_InBUS into the selected register; go to ACK.
  - IDLE, write_In=1, select invalid: no register written; increment errorCount, saturating at 255; go to NACK.
  - ACK or NACK, write_In=1: stay. Data and select are ignored.
  - ACK or NACK, write_In=0: go to IDLE.
- Outputs are Moore outputs:
  - ack_Out = (state==ACK).
  - error_Out = (state==NACK).
- Only the selected register changes on an accepted write; the other seven hold their values.
- One request produces exactly one write or one error count, regardless of how long write_In stays high.
- Reset values:
  - all eight data registers 0
  - ack_Out 0, error_Out 0
  - errorCount 0
  - state IDLE

## Timing

- Acceptance edge: the first rising clock edge with state IDLE and write_In=1.
  - data_InBUS and selection_InBUS are sampled only at this edge.
  - The selected dataN_OutBUS shows the new word right after this edge.
  - ack_Out (or error_Out) rises after the same edge, so the requester sees it the cycle after it raised write_In.
- ack_Out and error_Out fall on the first edge at which write_In=0 is sampled.
- Minimum handshake is 2 cycles. Back-to-back requests need write_In low for at least one sampled edge.
- write_In high continuously after a completed handshake is not a new request.
- Reset takes priority over every other event at the same edge.
  - Reset mid-handshake returns to IDLE and clears all registers, flags and the counter.
  - If write_In is still high on the first edge after reset is released, it is accepted as a new request.
- Counter saturation: at 255, further rejected requests still enter NACK and assert error_Out; the count stays at 255.
- Select or data changing while in ACK or NACK has no effect.

## Structure

- Shared package `demux_8_pkg` holds:
  - state encoding localparams (IDLE=2'd0, ACK=2'd1, NACK=2'd2; 2'd3 recovers to IDLE)
  - the eight select constants SEL_CH0…SEL_CH7
  - the error counter width (8) and saturation value (255)
- One sub-module, `demux_8_decoder` (combinational):
  - input: select code
  - outputs: 3-bit channel index and a valid bit
  - valid=1 only for the eight listed codes
  - the same constants can be reused to check the multiplexer's select path
- Top level contains the FSM, the write-enable generation (decoder index gated by the IDLE request), the eight registers and the counter.

## Test plan

- Reset, then write 32'hA5A5_0001 with select 8'hFE, lower write_In after ack → data0=32'hA5A5_0001, data1-7=0, ack high exactly 1 cycle after request, error 0, count 0.
- Sweep ch0-ch7 with data 32'h1000_0000+N, one full handshake each → each dataN holds its value; no cross-channel writes.
- Select 8'hFC, then 8'hFF, then 8'h00, each with a full handshake → no register changes, error_Out high for each, count=3, ack never asserted.
- Hold write_In high 10 cycles with select 8'hF7, changing data every cycle → data3 equals the word present at the acceptance edge only; ack held 10 cycles; one write.
- Assert reset while in ACK with write_In still high → all outputs 0 after that edge; after reset is released, the same request is accepted again.
- Issue 260 invalid requests → errorCount stops at 255; error_Out still pulses on the last 5 requests.
